// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack.
// Default geometry and the {push,pop} operation encoding used by the
// pointer logic and by anything that models the stack.
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Operation code formed as {push, pop}
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer and status logic for stack_param.
// Holds sp, decides whether and where the memory is written this cycle,
// and maintains the sticky overflow/underflow flags.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   push, pop        requested operation
//   clear            flush (sp -> 0), flags kept unless err_clr
//   err_clr          clear sticky flags (a same-cycle set wins)
//   sp               current number of valid entries
//   empty, full      sp == 0 / sp == DEPTH
//   overflow         sticky: push while full without pop
//   underflow        sticky: pop while empty
//   wr_en, wr_addr   memory write strobe and index for this cycle
//   rd_addr          index of the current top entry (valid when !empty)
module stack_ptr
    import stack_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic          err_clr,
    output logic [CW-1:0] sp,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr
);

    logic [CW-1:0] sp_q, sp_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          set_ovf;
    logic          set_unf;
    logic          is_empty;
    logic          is_full;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == CW'(DEPTH));

    always_comb begin
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = AW'(sp_q);

        if (clear) begin
            sp_d = '0;
        end else begin
            case ({push, pop})
                OP_PUSH: begin
                    if (is_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = AW'(sp_q);
                        sp_d    = sp_q + 1'b1;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        sp_d = sp_q - 1'b1;
                    end
                end
                OP_REPL: begin
                    if (is_empty) begin
                        // Replace on an empty stack degrades to a plain push
                        // but still reports the pop that had nothing to take.
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        sp_d    = CW'(1);
                        set_unf = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = AW'(sp_q - 1'b1);
                    end
                end
                default: begin
                end
            endcase
        end

        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (set_ovf) begin
            overflow_d = 1'b1;
        end
        if (set_unf) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign sp        = sp_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    // Wraps when empty; the top level masks data_out in that case.
    assign rd_addr   = AW'(sp_q - 1'b1);

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack with replace-top, occupancy count, sticky
// error flags and synchronous clear.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   push       write data_in onto the stack
//   pop        remove the top entry
//   clear      flush the stack, flags kept
//   err_clr    clear sticky error flags
//   data_in    word to push
//   data_out   top of stack, zero when empty (registered state only)
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky push-while-full
//   underflow  sticky pop-while-empty
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             empty_w;

    stack_ptr #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .AW    (AW)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .err_clr   (err_clr),
        .sp        (count),
        .empty     (empty_w),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr)
    );

    always_comb begin
        mem_d = mem_q;
        // Reset suppresses writes even though memory contents are don't-care.
        if (wr_en && rst) begin
            mem_d[wr_addr] = data_in;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty    = empty_w;
    assign data_out = empty_w ? '0 : mem_q[rd_addr];

endmodule

// File: tb/tb_stack_param.sv
module tb_stack_param;
    import stack_pkg::*;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clear;
    logic       err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int n_cmp;
    int n_err;

    stack_param #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .err_clr   (err_clr),
        .data_in   (data_in),
        .data_out  (data_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clocked operation, inputs returned to idle afterwards.
    task automatic op(input logic [1:0] code, input logic [7:0] d);
        {push, pop} = code;
        data_in = d;
        tick();
        {push, pop} = OP_NONE;
    endtask

    task automatic test_reset();
        rst = 1'b0; push = 1'b1; data_in = 8'hAA;
        tick(); tick();
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data_out); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
        rst = 1'b1; data_in = 8'h11;
        tick();
        push = 1'b0;
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL first_push_count got %0d exp 1", count); end
        n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL first_push_data got %h exp 11", data_out); end
    endtask

    task automatic test_fill();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            op(OP_PUSH, 8'(i));
            n_cmp++; if (count !== 5'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", full); end
        n_cmp++; if (data_out !== 8'h10) begin n_err++; $display("FAIL fill_top got %h exp 10", data_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_no_ovf got %b exp 0", overflow); end
        op(OP_PUSH, 8'hFF);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d exp 16", count); end
        n_cmp++; if (data_out !== 8'h10) begin n_err++; $display("FAIL ovf_top got %h exp 10", data_out); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL ovf_unf got %b exp 0", underflow); end
    endtask

    task automatic test_drain();
        for (int i = 16; i >= 1; i--) begin
            n_cmp++; if (data_out !== 8'(i)) begin n_err++; $display("FAIL drain_top[%0d] got %h exp %h", i, data_out, 8'(i)); end
            op(OP_POP, 8'h00);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b exp 1", empty); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL drain_data got %h exp 00", data_out); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL drain_no_unf got %b exp 0", underflow); end
        op(OP_POP, 8'h00);
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_set got %b exp 1", underflow); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL unf_count got %0d exp 0", count); end
    endtask

    task automatic test_replace();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL errclr_flags got %b exp 00", {overflow, underflow}); end
        op(OP_PUSH, 8'h01);
        op(OP_PUSH, 8'h02);
        op(OP_REPL, 8'h55);
        n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL repl_count got %0d exp 2", count); end
        n_cmp++; if (data_out !== 8'h55) begin n_err++; $display("FAIL repl_top got %h exp 55", data_out); end
        op(OP_POP, 8'h00);
        n_cmp++; if (data_out !== 8'h01) begin n_err++; $display("FAIL repl_pop got %h exp 01", data_out); end
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 1; i <= 16; i++) op(OP_PUSH, 8'(i + 32));
        op(OP_REPL, 8'hAB);
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL repl_full_count got %0d exp 16", count); end
        n_cmp++; if (data_out !== 8'hAB) begin n_err++; $display("FAIL repl_full_top got %h exp AB", data_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL repl_full_ovf0 got %b exp 0", overflow); end
        op(OP_PUSH, 8'hCD);
        op(OP_REPL, 8'hEF);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL repl_full_ovf1 got %b exp 1", overflow); end
        n_cmp++; if (data_out !== 8'hEF) begin n_err++; $display("FAIL repl_full_top2 got %h exp EF", data_out); end
    endtask

    task automatic test_repl_empty();
        clear = 1'b1; err_clr = 1'b1; tick(); clear = 1'b0; err_clr = 1'b0;
        n_cmp++; if ({count, overflow, underflow} !== 7'b0) begin n_err++; $display("FAIL clr_errclr got %0d/%b exp 0/00", count, {overflow, underflow}); end
        op(OP_REPL, 8'h33);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL repl_empty_count got %0d exp 1", count); end
        n_cmp++; if (data_out !== 8'h33) begin n_err++; $display("FAIL repl_empty_top got %h exp 33", data_out); end
        n_cmp++; if ({overflow, underflow} !== 2'b01) begin n_err++; $display("FAIL repl_empty_flags got %b exp 01", {overflow, underflow}); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL errclr2 got %b exp 00", {overflow, underflow}); end
        op(OP_POP, 8'h00);
        // Error set in the same cycle as err_clr must win.
        err_clr = 1'b1;
        op(OP_POP, 8'h00);
        err_clr = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL set_wins got %b exp 1", underflow); end
    endtask

    task automatic test_clear_reset();
        for (int i = 1; i <= 5; i++) op(OP_PUSH, 8'(i));
        n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL five_count got %0d exp 5", count); end
        clear = 1'b1;
        op(OP_PUSH, 8'h77);
        clear = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL clear_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1 || data_out !== 8'h00) begin n_err++; $display("FAIL clear_empty got %b/%h exp 1/00", empty, data_out); end
        n_cmp++; if ({overflow, underflow} !== 2'b01) begin n_err++; $display("FAIL clear_flags got %b exp 01", {overflow, underflow}); end
        // Back-to-back push burst interrupted by reset.
        push = 1'b1;
        data_in = 8'h61; tick();
        data_in = 8'h62; tick();
        rst = 1'b0; data_in = 8'h63; tick();
        n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL midreset_state got %0d/%b/%b exp 0/1/0", count, empty, full); end
        n_cmp++; if (data_out !== 8'h00 || {overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL midreset_out got %h/%b exp 00/00", data_out, {overflow, underflow}); end
        rst = 1'b1; data_in = 8'h44; tick();
        push = 1'b0;
        n_cmp++; if (count !== 5'd1 || data_out !== 8'h44) begin n_err++; $display("FAIL post_reset got %0d/%h exp 1/44", count, data_out); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_replace();
        test_repl_empty();
        test_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
Parametrised LIFO stack, the successor to the fixed 2-bit stack. Data width and depth are configurable. The block adds:
- simultaneous push+pop (replace top);
- a live occupancy count;
- sticky overflow/underflow error flags;
- a synchronous clear.

It serves as the operand/return-address store for datapath controllers in the CA designs.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, power of two not required)
CW, $clog2(DEPTH+1), width of count output (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock; single clock domain
rst  input  1  synchronous, active-low reset; sampled on rising clk
push  input  1  write data_in onto stack this cycle
pop  input  1  remove top entry this cycle
clear  input  1  synchronous flush; empties stack, keeps error flags
err_clr  input  1  clears sticky overflow/underflow flags
data_in  input  WIDTH  word to push
data_out  output  WIDTH  current top-of-stack (combinational peek)
count  output  CW  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full (without pop)
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst==0 at posedge):
  - sp=0, so count=0, empty=1, full=0, data_out=0.
  - overflow=0, underflow=0.
  - Memory contents are don't-care.
  - Reset overrides all other inputs, including mid-sequence.
- Storage: register array mem[0..DEPTH-1] plus stack pointer sp (CW bits). Top entry is mem[sp-1].
- data_out = mem[sp-1] when sp>0, else all zeros. It is combinational from registers, so a push is visible the cycle after its edge; there is no extra latency.
- Per-cycle priority, highest first: rst, clear, push/pop.
- clear=1: sp<=0. overflow/underflow are unchanged unless err_clr is also 1.
- push=1, pop=0:
  - Not full: mem[sp]<=data_in, sp<=sp+1.
  - Full: no state change to mem or sp; overflow<=1.
- push=0, pop=1:
  - Not empty: sp<=sp-1. Data is not erased.
  - Empty: no change; underflow<=1.
- push=1, pop=1 (replace):
  - Not empty (includes full): mem[sp-1]<=data_in, sp unchanged. No error.
  - Empty: treated as a plain push: mem[0]<=data_in, sp<=1, underflow<=1.
- push=0, pop=0: hold.
- err_clr=1: overflow<=0 and underflow<=0, unless the same cycle sets a flag; set wins.
- empty, full, and count are derived combinationally from sp. No glitches across wrap: sp never exceeds DEPTH and never goes below 0.
- All state updates occur on the rising clk edge only. Outputs have no combinational path from push, pop, or data_in.

Decomposition:
- Shared package stack_pkg:
  - default WIDTH/DEPTH constants;
  - the op encoding localparams OP_NONE, OP_PUSH, OP_POP, OP_REPL, built from {push,pop}, for the case statement and the bench scoreboard.
- One natural sub-module: stack_ptr, holding sp (count logic, full/empty, error-flag generation). The top level keeps the memory array and the data_out mux.

Test Plan:
1. Reset while holding push=1, data_in=8'hAA for 2 cycles -> count=0, empty=1, data_out=0, no write occurs. After rst=1, one push of 8'h11 -> count=1, data_out=8'h11.
2. Push 16 values 8'h01..8'h10 (DEPTH=16) -> full=1, count=16, data_out=8'h10. A 17th push of 8'hFF -> overflow=1, count=16, data_out=8'h10.
3. Pop 16 times from the full stack -> data_out sequence 8'h10 down to 8'h01, then empty=1, data_out=0. A 17th pop -> underflow=1, count=0.
4. Stack holds 8'h01,8'h02; push=pop=1 with data_in=8'h55 -> count=2, data_out=8'h55. Pop -> data_out=8'h01. On a full stack, push=pop=1 -> count stays 16, overflow unchanged.
5. push=pop=1 on an empty stack, data_in=8'h33 -> count=1, data_out=8'h33, underflow=1. Assert err_clr for 1 cycle -> both flags 0.
6. With 5 entries, assert clear and push together -> count=0, empty=1, flags unchanged. Then rst=0 mid-way through a push burst -> all outputs return to reset values on the next edge.
